regression_sequencer: RTL and testbench
=======================================

# regression_sequencer

Control FSM for the linear-regression datapath. It issues one-cycle start strobes in order: transpose, the X^T·X and X^T·y multiplies together, the 2×2 inverse, then the final multiply. It waits for each stage's done pulse before moving on. It aborts on a singular determinant, a stage timeout, bad input data or an external abort. It sits between the input-matrix loader and the arithmetic stages and replaces the current free-running chaining of done→start.

## Interface
Parameters:
- TIMEOUT_CYCLES, 15: maximum clock edges spent in a wait state without the required done; legal range 2..255.
- CNT_W, 8: width of the latency counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- go  in  1  request a regression run (level or pulse; sampled in IDLE only)
- abort  in  1  synchronous abort; returns to IDLE
- input_ready  in  1  input matrix loaded
- input_error  in  1  input loader reports bad values
- start_transpose  out  1  strobe to transpose stage
- done_transpose  in  1
- start_mul  out  1  strobe to both X^T·X and X^T·y multipliers
- done_xtx  in  1
- done_xty  in  1
- start_inverse  out  1
- done_inverse  in  1
- det_invalid  in  1  inverse stage's determinant==0 flag, qualified by done_inverse
- start_final  out  1
- done_final  in  1
- busy  out  1  high in any non-IDLE state
- result_valid  out  1  run completed successfully
- err  out  1  run terminated with error
- err_code  out  2  0 none, 1 singular, 2 timeout, 3 input error
- stage  out  3  current state encoding
- latency  out  CNT_W  cycles taken by the last or current run

## Operation
- States: IDLE, TRANSPOSE, MULTIPLY, INVERT, FINAL.
- All outputs are registered. Start strobes are one-cycle pulses issued in the first cycle after entering their state.
- Run acceptance, IDLE with go=1:
  - If input_error=1: stay in IDLE; set err=1, err_code=3; clear result_valid.
  - Else if input_ready=1: go to TRANSPOSE; clear result_valid, err, err_code and latency; pulse start_transpose.
  - Else: ignore go.
- TRANSPOSE: on done_transpose, go to MULTIPLY and pulse start_mul.
- MULTIPLY: done_xtx and done_xty are captured in sticky bits, so they may arrive in the same or different cycles. When both are seen, clear the sticky bits, go to INVERT and pulse start_inverse.
- INVERT: on done_inverse:
  - If det_invalid=1: go to IDLE; err=1, err_code=1.
  - Else: go to FINAL and pulse start_final.
- FINAL: on done_final, go to IDLE with result_valid=1.
- Timeout: the wait counter clears on every state entry and counts edges spent in a wait state without the required done. At the TIMEOUT_CYCLES-th such edge, go to IDLE with err=1, err_code=2.
- Done pulses that arrive in a state not expecting them are ignored. They are not captured for later states.
- abort=1 in any non-IDLE state: go to IDLE. Flags are left cleared (no result_valid, no err), strobes are suppressed and the sticky bits are cleared.
- abort outranks done, timeout and det_invalid in the same cycle. abort in IDLE has no effect.
- go while busy is ignored.
- result_valid, err and err_code hold until the next accepted go or an input-error go.
- latency increments on every edge while busy and saturates at 2^CNT_W−1. It freezes in IDLE.

## Timing
- Reset values: state IDLE; stage=0; all strobes 0; busy, result_valid, err 0; err_code 0; latency 0; sticky bits and wait counter 0.
- rst_n asserted mid-run forces IDLE immediately; no strobe may follow.
- Stage handoff costs one edge: done sampled at edge n gives the next strobe high after edge n.
- With all stages at 1-cycle latency, go sampled at edge 0 gives:
  - start_transpose after edge 0
  - start_mul after edge 2
  - start_inverse after edge 4
  - start_final after edge 6
  - result_valid=1 and busy=0 after edge 8; latency=8.
- Timeout path: error flags are visible after the timing-out edge, and busy drops in the same cycle.

## Structure
- Package regression_pkg holds:
  - the state enum (IDLE=0, TRANSPOSE=1, MULTIPLY=2, INVERT=3, FINAL=4)
  - the err_code enum
  - the TIMEOUT_CYCLES default.
- One sub-module, stage_watchdog, contains the wait counter.
  - Inputs: clear, count_en.
  - Output: expired.
  - Parameterised by TIMEOUT_CYCLES.
- FSM, sticky bits, flags and the latency counter live in regression_sequencer.

## Test plan
- Nominal run with 1-cycle stage models: pulse go → strobes after edges 0/2/4/6; result_valid=1 after edge 8; latency=8; err=0.
- Multiplier skew: done_xty 3 cycles after done_xtx → start_inverse only after the later done; reverse order gives the same result; latency=11.
- Singular: det_invalid=1 with done_inverse → err=1, err_code=1, start_final never pulses, busy=0.
- Timeout: withhold done_transpose → err_code=2 after the 15th wait edge; later stray done_transpose is ignored.
- Abort at the same edge as done_inverse → IDLE, no start_final, err=0, result_valid=0; go during a run is ignored; go with input_error=1 → err_code=3, no strobes.
- rst_n low during MULTIPLY → all outputs are reset values immediately; a fresh go afterwards completes normally.

Source files
------------

// File: rtl/regression_pkg.sv
// rtl/regression_pkg.sv - shared states, error codes and defaults for the regression sequencer
// Contents:
//   TIMEOUT_CYCLES_DEF - default wait-state timeout in clock edges
//   state_e            - sequencer FSM state encoding (also driven out on stage)
//   err_code_e         - run termination reason reported on err_code
package regression_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRANSPOSE = 3'd1,
        ST_MULTIPLY  = 3'd2,
        ST_INVERT    = 3'd3,
        ST_FINAL     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_SINGULAR = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_INPUT    = 2'd3
    } err_code_e;

endpackage

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - wait-state edge counter that flags a stage timeout
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - restart the count (state entry or idle)
//   count_en   - an edge is being spent waiting for a done
//   expired    - this edge is the TIMEOUT_CYCLES-th waiting edge
module stage_watchdog
    import regression_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // expired looks only at the registered count so that the FSM can use it
    // while the clear input (derived from the next state) stays loop-free.
    assign expired = count_en && (count_q == LAST_COUNT);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (count_en) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/regression_sequencer.sv
// rtl/regression_sequencer.sv - control FSM sequencing the linear-regression datapath stages
// Ports:
//   clk, rst_n                         - clock, asynchronous active-low reset
//   go, abort                          - run request (sampled in IDLE), synchronous abort
//   input_ready, input_error           - loader status
//   start_*/done_*                     - per-stage start strobes and done pulses
//   det_invalid                        - singular determinant, qualified by done_inverse
//   busy, result_valid, err, err_code  - run status
//   stage                              - current FSM state
//   latency                            - edges spent busy in the last or current run
module regression_sequencer
    import regression_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             abort,
    input  logic             input_ready,
    input  logic             input_error,
    output logic             start_transpose,
    input  logic             done_transpose,
    output logic             start_mul,
    input  logic             done_xtx,
    input  logic             done_xty,
    output logic             start_inverse,
    input  logic             done_inverse,
    input  logic             det_invalid,
    output logic             start_final,
    input  logic             done_final,
    output logic             busy,
    output logic             result_valid,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [2:0]       stage,
    output logic [CNT_W-1:0] latency
);

    localparam logic [CNT_W-1:0] LAT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic             xtx_seen_q, xtx_seen_d;
    logic             xty_seen_q, xty_seen_d;
    logic             st_transpose_q, st_transpose_d;
    logic             st_mul_q, st_mul_d;
    logic             st_inverse_q, st_inverse_d;
    logic             st_final_q, st_final_d;
    logic             busy_q;
    logic             result_valid_q, result_valid_d;
    logic             err_q, err_d;
    err_code_e        err_code_q, err_code_d;
    logic [CNT_W-1:0] latency_q, latency_d;

    logic             wd_clear;
    logic             wd_count_en;
    logic             wd_expired;
    logic             xtx_now;
    logic             xty_now;

    assign wd_count_en = (state_q != ST_IDLE);
    assign wd_clear    = (state_q == ST_IDLE) || (state_d != state_q);

    stage_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .count_en(wd_count_en),
        .expired (wd_expired)
    );

    assign xtx_now = xtx_seen_q || done_xtx;
    assign xty_now = xty_seen_q || done_xty;

    always_comb begin
        state_d        = state_q;
        xtx_seen_d     = xtx_seen_q;
        xty_seen_d     = xty_seen_q;
        st_transpose_d = 1'b0;
        st_mul_d       = 1'b0;
        st_inverse_d   = 1'b0;
        st_final_d     = 1'b0;
        result_valid_d = result_valid_q;
        err_d          = err_q;
        err_code_d     = err_code_q;
        latency_d      = latency_q;

        if (state_q != ST_IDLE && latency_q != LAT_MAX) begin
            latency_d = latency_q + 1'b1;
        end

        if (state_q != ST_IDLE && abort) begin
            // Abort wins over any done/timeout this cycle; flags were already
            // cleared when the run was accepted, so they simply stay cleared.
            state_d    = ST_IDLE;
            xtx_seen_d = 1'b0;
            xty_seen_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        if (input_error) begin
                            result_valid_d = 1'b0;
                            err_d          = 1'b1;
                            err_code_d     = ERR_INPUT;
                        end else if (input_ready) begin
                            state_d        = ST_TRANSPOSE;
                            st_transpose_d = 1'b1;
                            result_valid_d = 1'b0;
                            err_d          = 1'b0;
                            err_code_d     = ERR_NONE;
                            latency_d      = '0;
                        end
                    end
                end
                ST_TRANSPOSE: begin
                    if (done_transpose) begin
                        state_d  = ST_MULTIPLY;
                        st_mul_d = 1'b1;
                    end else if (wd_expired) begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                ST_MULTIPLY: begin
                    if (xtx_now && xty_now) begin
                        state_d      = ST_INVERT;
                        st_inverse_d = 1'b1;
                        xtx_seen_d   = 1'b0;
                        xty_seen_d   = 1'b0;
                    end else if (wd_expired) begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                        xtx_seen_d = 1'b0;
                        xty_seen_d = 1'b0;
                    end else begin
                        xtx_seen_d = xtx_now;
                        xty_seen_d = xty_now;
                    end
                end
                ST_INVERT: begin
                    if (done_inverse) begin
                        if (det_invalid) begin
                            state_d    = ST_IDLE;
                            err_d      = 1'b1;
                            err_code_d = ERR_SINGULAR;
                        end else begin
                            state_d    = ST_FINAL;
                            st_final_d = 1'b1;
                        end
                    end else if (wd_expired) begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                ST_FINAL: begin
                    if (done_final) begin
                        state_d        = ST_IDLE;
                        result_valid_d = 1'b1;
                    end else if (wd_expired) begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    xtx_seen_d = 1'b0;
                    xty_seen_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            xtx_seen_q     <= 1'b0;
            xty_seen_q     <= 1'b0;
            st_transpose_q <= 1'b0;
            st_mul_q       <= 1'b0;
            st_inverse_q   <= 1'b0;
            st_final_q     <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= ERR_NONE;
            latency_q      <= '0;
        end else begin
            state_q        <= state_d;
            xtx_seen_q     <= xtx_seen_d;
            xty_seen_q     <= xty_seen_d;
            st_transpose_q <= st_transpose_d;
            st_mul_q       <= st_mul_d;
            st_inverse_q   <= st_inverse_d;
            st_final_q     <= st_final_d;
            busy_q         <= (state_d != ST_IDLE);
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            latency_q      <= latency_d;
        end
    end

    assign start_transpose = st_transpose_q;
    assign start_mul       = st_mul_q;
    assign start_inverse   = st_inverse_q;
    assign start_final     = st_final_q;
    assign busy            = busy_q;
    assign result_valid    = result_valid_q;
    assign err             = err_q;
    assign err_code        = err_code_q;
    assign stage           = state_q;
    assign latency         = latency_q;

endmodule

// File: tb/tb_regression_sequencer.sv
// tb/tb_regression_sequencer.sv - directed self-checking bench for regression_sequencer
module tb_regression_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic       abort = 1'b0;
    logic       input_ready = 1'b0;
    logic       input_error = 1'b0;
    logic       start_transpose;
    logic       done_transpose = 1'b0;
    logic       start_mul;
    logic       done_xtx = 1'b0;
    logic       done_xty = 1'b0;
    logic       start_inverse;
    logic       done_inverse = 1'b0;
    logic       det_invalid = 1'b0;
    logic       start_final;
    logic       done_final = 1'b0;
    logic       busy;
    logic       result_valid;
    logic       err;
    logic [1:0] err_code;
    logic [2:0] stage;
    logic [7:0] latency;

    int n_checks = 0;
    int n_errors = 0;
    int n_st = 0;
    int n_mul = 0;
    int n_inv = 0;
    int n_fin = 0;
    int snap_st;
    int snap_mul;
    int snap_fin;

    regression_sequencer #(
        .TIMEOUT_CYCLES(15),
        .CNT_W         (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .go             (go),
        .abort          (abort),
        .input_ready    (input_ready),
        .input_error    (input_error),
        .start_transpose(start_transpose),
        .done_transpose (done_transpose),
        .start_mul      (start_mul),
        .done_xtx       (done_xtx),
        .done_xty       (done_xty),
        .start_inverse  (start_inverse),
        .done_inverse   (done_inverse),
        .det_invalid    (det_invalid),
        .start_final    (start_final),
        .done_final     (done_final),
        .busy           (busy),
        .result_valid   (result_valid),
        .err            (err),
        .err_code       (err_code),
        .stage          (stage),
        .latency        (latency)
    );

    always #5 clk = ~clk;

    // Strobe pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (start_transpose) n_st++;
        if (start_mul)       n_mul++;
        if (start_inverse)   n_inv++;
        if (start_final)     n_fin++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample go at the next edge (edge 0 of a run).
    task automatic accept_go();
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    // Full run with 1-cycle stages; skew>0 delays done_xty, skew<0 delays done_xtx.
    task automatic run_skew(input string tag, input int skew);
        int dx;
        int dy;
        int m;
        dx = (skew < 0) ? -skew : 0;
        dy = (skew > 0) ? skew : 0;
        m  = (dx > dy) ? dx : dy;
        accept_go();
        check({tag, " start_transpose e0"}, start_transpose, 1);
        check({tag, " busy e0"}, busy, 1);
        check({tag, " latency e0"}, latency, 0);
        step();
        check({tag, " start_transpose e1"}, start_transpose, 0);
        done_transpose = 1'b1;
        step();
        done_transpose = 1'b0;
        check({tag, " start_mul e2"}, start_mul, 1);
        check({tag, " stage e2"}, stage, 2);
        step();
        for (int e = 4; e <= 4 + m; e++) begin
            done_xtx = (e == 4 + dx);
            done_xty = (e == 4 + dy);
            step();
            if (e < 4 + m) check({tag, " early start_inverse"}, start_inverse, 0);
        end
        done_xtx = 1'b0;
        done_xty = 1'b0;
        check({tag, " start_inverse"}, start_inverse, 1);
        step();
        done_inverse = 1'b1;
        step();
        done_inverse = 1'b0;
        check({tag, " start_final"}, start_final, 1);
        step();
        done_final = 1'b1;
        step();
        done_final = 1'b0;
        check({tag, " result_valid"}, result_valid, 1);
        check({tag, " busy end"}, busy, 0);
        check({tag, " err end"}, err, 0);
        check({tag, " latency end"}, latency, 8 + m);
    endtask

    initial begin
        // Reset values
        #2;
        check("reset stage", stage, 0);
        check("reset busy", busy, 0);
        check("reset strobes", {start_transpose, start_mul, start_inverse, start_final}, 0);
        check("reset flags", {result_valid, err, err_code}, 0);
        check("reset latency", latency, 0);
        @(negedge clk);
        rst_n = 1'b1;
        input_ready = 1'b1;
        step();

        run_skew("nominal", 0);
        run_skew("skew_xty", 3);
        run_skew("skew_xtx", -3);

        // Singular determinant
        snap_fin = n_fin;
        accept_go();
        step();
        done_transpose = 1'b1;
        step();
        done_transpose = 1'b0;
        step();
        done_xtx = 1'b1;
        done_xty = 1'b1;
        step();
        done_xtx = 1'b0;
        done_xty = 1'b0;
        step();
        done_inverse = 1'b1;
        det_invalid = 1'b1;
        step();
        done_inverse = 1'b0;
        det_invalid = 1'b0;
        check("singular err", err, 1);
        check("singular code", err_code, 1);
        check("singular busy", busy, 0);
        check("singular rv", result_valid, 0);
        step();
        step();
        check("singular no start_final", n_fin - snap_fin, 0);

        // Timeout in TRANSPOSE
        accept_go();
        check("timeout cleared err", err, 0);
        for (int i = 1; i <= 14; i++) step();
        check("timeout busy e14", busy, 1);
        check("timeout err e14", err, 0);
        step();
        check("timeout err e15", err, 1);
        check("timeout code", err_code, 2);
        check("timeout busy e15", busy, 0);
        check("timeout stage", stage, 0);
        snap_mul = n_mul;
        done_transpose = 1'b1;
        step();
        done_transpose = 1'b0;
        step();
        check("stray done_transpose", n_mul - snap_mul, 0);
        check("stray busy", busy, 0);
        check("stray code held", err_code, 2);

        // Abort at the same edge as done_inverse
        snap_fin = n_fin;
        accept_go();
        step();
        done_transpose = 1'b1;
        step();
        done_transpose = 1'b0;
        step();
        done_xtx = 1'b1;
        done_xty = 1'b1;
        step();
        done_xtx = 1'b0;
        done_xty = 1'b0;
        step();
        done_inverse = 1'b1;
        abort = 1'b1;
        step();
        done_inverse = 1'b0;
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort err", err, 0);
        check("abort rv", result_valid, 0);
        step();
        check("abort no start_final", n_fin - snap_fin, 0);

        // go held during a run is ignored
        snap_st = n_st;
        accept_go();
        go = 1'b1;
        step();
        step();
        step();
        go = 1'b0;
        check("go busy single strobe", n_st - snap_st, 1);
        check("go busy stage", stage, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort transpose busy", busy, 0);

        // go with input_error
        snap_st = n_st;
        input_error = 1'b1;
        accept_go();
        input_error = 1'b0;
        check("input_error err", err, 1);
        check("input_error code", err_code, 3);
        check("input_error busy", busy, 0);
        step();
        check("input_error no strobe", n_st - snap_st, 0);

        // Reset during MULTIPLY with one multiplier already done
        accept_go();
        step();
        done_transpose = 1'b1;
        step();
        done_transpose = 1'b0;
        step();
        done_xtx = 1'b1;
        step();
        done_xtx = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset stage", stage, 0);
        check("midreset latency", latency, 0);
        check("midreset outputs", {start_transpose, start_mul, start_inverse, start_final, result_valid, err, err_code}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_skew("after_reset", 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
